// File: rtl/lvds_train_pkg.sv
// rtl/lvds_train_pkg.sv - shared states and default constants for the LVDS training scheduler
package lvds_train_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECT    = 3'd1,
    START     = 3'd2,
    WAIT_CLR  = 3'd3,
    WAIT_DONE = 3'd4,
    EVAL      = 3'd5,
    NEXT      = 3'd6,
    FINISH    = 3'd7
  } train_state_e;

  localparam int unsigned DEF_START_HOLD  = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 1048575;
  // Timeout counter never narrower than this, whatever TIMEOUT_CYC is.
  localparam int unsigned MIN_TO_W        = 20;

endpackage

// File: rtl/train_timeout_cnt.sv
// rtl/train_timeout_cnt.sv - clear/enable saturating counter with terminal flag
module train_timeout_cnt #(
  parameter int unsigned    W   = 20,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [W-1:0] count;

  // Count up while enabled, stick at MAX so the terminal flag cannot wrap away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == MAX);

endmodule

// File: rtl/lvds_train_sched.sv
// rtl/lvds_train_sched.sv - sequential per-channel LVDS training scheduler (optional retry: LVDS_TRAIN_AUTO_RETRY_EN)
module lvds_train_sched
  import lvds_train_pkg::*;
#(
  parameter int unsigned  CH_NUM      = 4,
  parameter int unsigned  START_HOLD  = DEF_START_HOLD,
  parameter int unsigned  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned  MAX_RETRY   = 3,
  localparam int unsigned CW          = $clog2(CH_NUM + 1),
  localparam int unsigned RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk_rxg,
  input  logic              rst_rx_n,
  input  logic              train_req,
  input  logic              train_abort,
  input  logic [CH_NUM-1:0] ch_mask,
  input  logic [CH_NUM-1:0] training_done,
  input  logic [CH_NUM-1:0] loc_ok,
  output logic [CH_NUM-1:0] cmd_start_training,
  output logic              busy,
  output logic              all_done,
  output logic              all_ok,
  output logic [CH_NUM-1:0] ch_ok,
  output logic [CH_NUM-1:0] ch_fail,
  output logic              timeout_flag,
  output logic [CW-1:0]     cur_ch,
  output logic [RW-1:0]     retry_cnt
);

  localparam int unsigned     HW     = $clog2(START_HOLD);
  localparam int unsigned     TW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned     TW     = (TW_RAW > MIN_TO_W) ? TW_RAW : MIN_TO_W;
  localparam logic [CW-1:0]   CH_END = CW'(CH_NUM);
  localparam logic [CH_NUM-1:0] CH_ONE = CH_NUM'(1);

  train_state_e      state, state_n;
  logic [CH_NUM-1:0] mask_q;
  logic [CH_NUM-1:0] ch_sel;
  logic              sel_en, done_cur, lok_cur;
  logic              hold_end, to_term, in_wait;
  logic              att_to, eval_pass, eval_retry;

  // One-hot of the channel in service; all-zero once cur_ch has run past the last channel.
  assign ch_sel    = CH_ONE << cur_ch;
  assign sel_en    = |(mask_q & ch_sel);
  assign done_cur  = |(training_done & ch_sel);
  assign lok_cur   = |(loc_ok & ch_sel);
  assign in_wait   = (state == WAIT_CLR) || (state == WAIT_DONE);
  assign eval_pass = lok_cur && !att_to;

  train_timeout_cnt #(.W(HW), .MAX(HW'(START_HOLD - 1))) u_hold_cnt (
    .clk   (clk_rxg),
    .rst_n (rst_rx_n),
    .clr   (state != START),
    .en    (1'b1),
    .term  (hold_end)
  );

  train_timeout_cnt #(.W(TW), .MAX(TW'(TIMEOUT_CYC))) u_to_cnt (
    .clk   (clk_rxg),
    .rst_n (rst_rx_n),
    .clr   (state == START),
    .en    (in_wait),
    .term  (to_term)
  );

`ifdef LVDS_TRAIN_AUTO_RETRY_EN
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  assign eval_retry = !eval_pass && (retry_cnt < RETRY_MAX);

  // Repeat counter for the channel in service; restarts whenever a channel is picked.
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      retry_cnt <= '0;
    end else if (state == SELECT) begin
      retry_cnt <= '0;
    end else if ((state == EVAL) && eval_retry && !train_abort) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign eval_retry = 1'b0;
  assign retry_cnt  = '0;
`endif

  // State register.
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) state <= IDLE;
    else           state <= state_n;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (train_req) state_n = SELECT;
      SELECT:    if (cur_ch == CH_END) state_n = FINISH;
                 else if (sel_en)      state_n = START;
      START:     if (hold_end) state_n = WAIT_CLR;
      WAIT_CLR:  if (to_term)        state_n = EVAL;
                 else if (!done_cur) state_n = WAIT_DONE;
      WAIT_DONE: if (to_term || done_cur) state_n = EVAL;
      EVAL:      state_n = eval_retry ? START : NEXT;
      NEXT:      state_n = SELECT;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (train_abort && (state != IDLE)) state_n = IDLE;
  end

  // Pass bookkeeping: mask latch, channel pointer, sticky results and the start drive.
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      mask_q             <= '0;
      cur_ch             <= '0;
      ch_ok              <= '0;
      ch_fail            <= '0;
      timeout_flag       <= 1'b0;
      att_to             <= 1'b0;
      all_done           <= 1'b0;
      all_ok             <= 1'b0;
      busy               <= 1'b0;
      cmd_start_training <= '0;
    end else begin
      busy               <= (state_n != IDLE);
      cmd_start_training <= ((state == START) && !train_abort) ? ch_sel : '0;
      if (train_abort && (state != IDLE)) begin
        all_done <= 1'b0;
        all_ok   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (train_req) begin
              mask_q       <= ch_mask;
              ch_ok        <= '0;
              ch_fail      <= '0;
              timeout_flag <= 1'b0;
              all_done     <= 1'b0;
              all_ok       <= 1'b0;
              cur_ch       <= '0;
            end else if (train_abort) begin
              all_done <= 1'b0;
              all_ok   <= 1'b0;
            end
          end
          SELECT: begin
            // Flags are raised on the way into FINISH so they are visible during it.
            if (cur_ch == CH_END) begin
              all_done <= 1'b1;
              all_ok   <= (ch_ok == mask_q) && (mask_q != '0);
            end else if (!sel_en) begin
              cur_ch <= cur_ch + 1'b1;
            end
          end
          START: att_to <= 1'b0;
          WAIT_CLR, WAIT_DONE: begin
            if (to_term) begin
              timeout_flag <= 1'b1;
              att_to       <= 1'b1;
            end
          end
          EVAL: begin
            if (eval_pass)        ch_ok   <= ch_ok | ch_sel;
            else if (!eval_retry) ch_fail <= ch_fail | ch_sel;
          end
          NEXT: cur_ch <= cur_ch + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_train_sched.sv
// tb/tb_lvds_train_sched.sv - directed table-driven bench for lvds_train_sched
module tb_lvds_train_sched;

  localparam int CH   = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 1000;

  logic          clk_rxg = 1'b0;
  logic          rst_rx_n;
  logic          train_req, train_abort;
  logic [CH-1:0] ch_mask;
  logic [CH-1:0] training_done = '0;
  logic [CH-1:0] loc_ok = '0;
  logic [CH-1:0] cmd_start_training, ch_ok, ch_fail;
  logic          busy, all_done, all_ok, timeout_flag;
  logic [2:0]    cur_ch;
  logic [1:0]    retry_cnt;

  always #5 clk_rxg = ~clk_rxg;

  lvds_train_sched #(
    .CH_NUM(CH), .START_HOLD(HOLD), .TIMEOUT_CYC(TMO), .MAX_RETRY(3)
  ) dut (
    .clk_rxg            (clk_rxg),
    .rst_rx_n           (rst_rx_n),
    .train_req          (train_req),
    .train_abort        (train_abort),
    .ch_mask            (ch_mask),
    .training_done      (training_done),
    .loc_ok             (loc_ok),
    .cmd_start_training (cmd_start_training),
    .busy               (busy),
    .all_done           (all_done),
    .all_ok             (all_ok),
    .ch_ok              (ch_ok),
    .ch_fail            (ch_fail),
    .timeout_flag       (timeout_flag),
    .cur_ch             (cur_ch),
    .retry_cnt          (retry_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Aligner model state, one entry per channel.
  int            resp_delay = 20;
  int            stuck_hold [CH];
  int            fails_of   [CH];
  bit            hang       [CH];
  int            att        [CH];
  int            run_cnt    [CH];
  int            hold_cnt   [CH];
  int            hi_len     [CH];
  bit            running    [CH];
  logic [CH-1:0] prev_cmd = '0;
  bit            len_chk_en = 1'b1;
  int            len_err = 0;
  int            oh_err = 0;

  // Aligner model: on a start edge clear done (or keep a stale one for stuck_hold cycles),
  // then report done after resp_delay cycles; lock succeeds once attempts exceed fails_of.
  always @(negedge clk_rxg) begin
    for (int i = 0; i < CH; i++) begin
      if (cmd_start_training[i] && !prev_cmd[i]) begin
        att[i]++;
        hold_cnt[i] = stuck_hold[i];
        run_cnt[i]  = resp_delay;
        running[i]  = 1'b1;
        if (stuck_hold[i] == 0) begin
          training_done[i] = 1'b0;
          loc_ok[i]        = 1'b0;
        end
      end else if (running[i]) begin
        if (hold_cnt[i] > 0) begin
          hold_cnt[i]--;
          if (hold_cnt[i] == 0) begin
            training_done[i] = 1'b0;
            loc_ok[i]        = 1'b0;
          end
        end else if (run_cnt[i] > 0) begin
          run_cnt[i]--;
        end else if (!hang[i]) begin
          training_done[i] = 1'b1;
          loc_ok[i]        = (att[i] > fails_of[i]);
          running[i]       = 1'b0;
        end
      end
      if (cmd_start_training[i]) begin
        hi_len[i]++;
      end else if (prev_cmd[i]) begin
        if (len_chk_en && (hi_len[i] != HOLD)) len_err++;
        hi_len[i] = 0;
      end
    end
    if ($countones(cmd_start_training) > 1) oh_err++;
    prev_cmd = cmd_start_training;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_cfg(input logic [3:0] hang_m, input int ch1_fails, input int ch0_stuck, input int ch0_fails);
    for (int i = 0; i < CH; i++) begin
      att[i]        = 0;
      running[i]    = 1'b0;
      hang[i]       = hang_m[i];
      stuck_hold[i] = (i == 0) ? ch0_stuck : 0;
      fails_of[i]   = (i == 1) ? ch1_fails : ((i == 0) ? ch0_fails : 0);
    end
  endtask

  task automatic run_pass(input logic [3:0] m, output bit fin);
    ch_mask   = m;
    train_req = 1'b1;
    @(negedge clk_rxg);
    train_req = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (all_done) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk_rxg);
    end
  endtask

  function automatic logic [15:0] pack_starts();
    logic [15:0] sp;
    for (int i = 0; i < CH; i++) sp[i*4 +: 4] = att[i][3:0];
    return sp;
  endfunction

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  hang;
    int          ch1_fails;
    logic [3:0]  exp_ok;
    logic [3:0]  exp_fail;
    logic        exp_all_ok;
    logic        exp_to;
    logic [15:0] exp_starts;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit fin;
    bit seen;

    vecs[0] = '{4'hF, 4'h0, 0, 4'hF, 4'h0, 1'b1, 1'b0, 16'h1111};
    vecs[1] = '{4'h5, 4'h0, 0, 4'h5, 4'h0, 1'b1, 1'b0, 16'h0101};
`ifdef LVDS_TRAIN_AUTO_RETRY_EN
    vecs[2] = '{4'hF, 4'h0, 2, 4'hF, 4'h0, 1'b1, 1'b0, 16'h1131};
    vecs[3] = '{4'hF, 4'h4, 0, 4'hB, 4'h4, 1'b0, 1'b1, 16'h1411};
`else
    vecs[2] = '{4'hF, 4'h0, 2, 4'hD, 4'h2, 1'b0, 1'b0, 16'h1111};
    vecs[3] = '{4'hF, 4'h4, 0, 4'hB, 4'h4, 1'b0, 1'b1, 16'h1111};
`endif
    vecs[4] = '{4'h0, 4'h0, 0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};

    model_cfg(4'h0, 0, 0, 0);
    for (int i = 0; i < CH; i++) hi_len[i] = 0;
    rst_rx_n    = 1'b0;
    train_req   = 1'b0;
    train_abort = 1'b0;
    ch_mask     = '0;

    // Reset state.
    repeat (3) @(negedge clk_rxg);
    check("rst_busy", busy, 0);
    check("rst_all_done", all_done, 0);
    check("rst_all_ok", all_ok, 0);
    check("rst_ch_ok", ch_ok, 0);
    check("rst_ch_fail", ch_fail, 0);
    check("rst_timeout", timeout_flag, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_cmd", cmd_start_training, 0);
    check("rst_retry_cnt", retry_cnt, 0);
    rst_rx_n = 1'b1;
    repeat (2) @(negedge clk_rxg);

    // Start timing, done-to-result latency and masked-channel skip cost, mask 0001.
    ch_mask   = 4'b0001;
    train_req = 1'b1;                       // cycle 0
    @(negedge clk_rxg); train_req = 1'b0;   // cycle 1
    check("a_busy_c1", busy, 1);
    @(negedge clk_rxg);                     // cycle 2
    check("a_cmd_c2", cmd_start_training, 4'b0000);
    check("a_cur_ch_c2", cur_ch, 0);
    @(negedge clk_rxg);                     // cycle 3
    check("a_cmd_c3", cmd_start_training, 4'b0001);
    repeat (7) @(negedge clk_rxg);          // cycle 10
    check("a_cmd_c10", cmd_start_training, 4'b0001);
    @(negedge clk_rxg);                     // cycle 11
    check("a_cmd_c11", cmd_start_training, 4'b0000);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_rxg); #1;
      if (training_done[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("a_done_seen", seen, 1);
    check("a_ch_ok_t1", ch_ok, 4'b0000);
    @(posedge clk_rxg); #1;
    check("a_ch_ok_t2", ch_ok, 4'b0001);
    repeat (4) @(posedge clk_rxg); #1;
    check("a_all_done_t6", all_done, 0);
    @(posedge clk_rxg); #1;
    check("a_all_done_t7", all_done, 1);
    check("a_all_ok", all_ok, 1);

    // Table of full passes.
    resp_delay = 500;
    for (int v = 0; v < 5; v++) begin
      repeat (2) @(negedge clk_rxg);
      model_cfg(vecs[v].hang, vecs[v].ch1_fails, 0, 0);
      run_pass(vecs[v].mask, fin);
      check($sformatf("v%0d_all_done", v), fin, 1);
      check($sformatf("v%0d_ch_ok", v), ch_ok, vecs[v].exp_ok);
      check($sformatf("v%0d_ch_fail", v), ch_fail, vecs[v].exp_fail);
      check($sformatf("v%0d_all_ok", v), all_ok, vecs[v].exp_all_ok);
      check($sformatf("v%0d_timeout", v), timeout_flag, vecs[v].exp_to);
      check($sformatf("v%0d_starts", v), pack_starts(), vecs[v].exp_starts);
    end

    // Stale done on channel 0 (left high with lock by the earlier pass) must not pass.
    repeat (2) @(negedge clk_rxg);
    resp_delay = 40;
    model_cfg(4'h0, 0, 30, 100);
    ch_mask   = 4'b0001;
    train_req = 1'b1;
    @(negedge clk_rxg); train_req = 1'b0;
    repeat (25) @(negedge clk_rxg);
    check("stuck_busy", busy, 1);
    check("stuck_no_pass", ch_ok, 4'b0000);
    fin = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (all_done) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk_rxg);
    end
    check("stuck_all_done", fin, 1);
    check("stuck_ch_ok", ch_ok, 4'b0000);
    check("stuck_ch_fail", ch_fail, 4'b0001);
    check("stuck_all_ok", all_ok, 0);
    check("stuck_timeout", timeout_flag, 0);
`ifdef LVDS_TRAIN_AUTO_RETRY_EN
    check("stuck_starts", pack_starts(), 16'h0004);
`else
    check("stuck_starts", pack_starts(), 16'h0001);
`endif

    // Abort while channel 1 is being started.
    repeat (2) @(negedge clk_rxg);
    resp_delay = 20;
    len_chk_en = 1'b0;
    model_cfg(4'h0, 0, 0, 0);
    ch_mask   = 4'hF;
    train_req = 1'b1;
    @(negedge clk_rxg); train_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (cmd_start_training[1]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_rxg);
    end
    check("abort_ch1_started", seen, 1);
    check("abort_cur_ch", cur_ch, 1);
    repeat (2) @(negedge clk_rxg);
    train_abort = 1'b1;
    @(negedge clk_rxg); train_abort = 1'b0;
    check("abort_cmd", cmd_start_training, 4'b0000);
    check("abort_busy", busy, 0);
    check("abort_all_done", all_done, 0);
    check("abort_ch_ok", ch_ok, 4'b0001);
    check("abort_ch_fail", ch_fail, 4'b0000);
    repeat (3) @(negedge clk_rxg);
    check("abort_no_later_starts", pack_starts(), 16'h0011);

    // Empty mask: finishes within 6 cycles, never ok.
    ch_mask   = 4'b0000;
    train_req = 1'b1;                       // cycle 0
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_rxg);
      if (k == 1) train_req = 1'b0;
      if (k == 5) check("mask0_all_done_c5", all_done, 0);
      if (k == 6) begin
        check("mask0_all_done_c6", all_done, 1);
        check("mask0_all_ok", all_ok, 0);
        check("mask0_ch_ok", ch_ok, 4'b0000);
      end
    end

    repeat (2) @(negedge clk_rxg);
    check("start_len_errs", len_err, 0);
    check("onehot_errs", oh_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_train_sched.md
# lvds_train_sched

Training scheduler for the LVDS receive front end. It sequences bit/word alignment across `CH_NUM` per-channel aligners, one channel at a time, all in the `clk_rxg` domain. For each enabled channel it pulses the channel's start-training level, waits for the done flag with a timeout, grades the result from `loc_ok`, and optionally retries. It reports per-channel and aggregate status to the link-management logic.

## Interface
Parameters:
- `CH_NUM`, default 4: number of aligner channels (1..12).
- `START_HOLD`, default 8: cycles `cmd_start_training` is held high (≥4, so the aligner's 2-flop edge detector sees it).
- `TIMEOUT_CYC`, default 1048575: maximum cycles spent in WAIT_CLR plus WAIT_DONE per attempt.
- `MAX_RETRY`, default 3: extra attempts per channel (used only with the retry macro).

Ports:
- `clk_rxg` in 1: receive global clock; the only clock.
- `rst_rx_n` in 1: reset, asynchronous, active-low.
- `train_req` in 1: single-cycle request to start a training pass.
- `train_abort` in 1: abandon the pass in progress.
- `ch_mask` in `CH_NUM`: channel enables, latched on an accepted `train_req`.
- `training_done` in `CH_NUM`: aligner done flags. Each is a level, cleared by the aligner when it starts.
- `loc_ok` in `CH_NUM`: aligner word-lock result, valid while the matching `training_done` is 1.
- `cmd_start_training` out `CH_NUM`: per-channel start level.
- `busy` out 1: a pass is in progress.
- `all_done` out 1: the pass completed. Sticky until the next accepted `train_req` or `train_abort`.
- `all_ok` out 1: every enabled channel locked. Forced 0 when the latched mask is all-zero.
- `ch_ok` out `CH_NUM`, `ch_fail` out `CH_NUM`: per-channel sticky results for the pass.
- `timeout_flag` out 1: sticky. Set on any attempt that timed out during the pass.
- `cur_ch` out `$clog2(CH_NUM+1)`: channel under service.
- `retry_cnt` out `$clog2(MAX_RETRY+1)`: attempts already repeated on `cur_ch`.

## Operation
- All outputs are registered. Reset value of every output is 0.
- State machine:
  - **IDLE**: `busy`=0. On `train_req`: latch the mask; clear `ch_ok`, `ch_fail`, `timeout_flag`, `all_done`, `all_ok`; set `cur_ch`=0; go to SELECT.
  - **SELECT**:
    - `cur_ch`==`CH_NUM` goes to FINISH.
    - A masked-off channel: `cur_ch`+1, stay in SELECT.
    - Otherwise: `retry_cnt`=0, go to START.
  - **START**: drive `cmd_start_training[cur_ch]`=1 for exactly `START_HOLD` cycles. Clear the timeout counter. Go to WAIT_CLR.
  - **WAIT_CLR**: wait for `training_done[cur_ch]`==0, then go to WAIT_DONE. This prevents accepting a stale done flag from a previous run.
  - **WAIT_DONE**: `training_done[cur_ch]`==1 goes to EVAL.
  - **Timeout** (WAIT_CLR or WAIT_DONE): when the counter reaches `TIMEOUT_CYC`, set `timeout_flag` and go to EVAL with the attempt marked failed.
  - **EVAL**:
    - Pass: `loc_ok[cur_ch]`=1 and no timeout. Set `ch_ok[cur_ch]`, go to NEXT.
    - Fail with retries left (macro defined and `retry_cnt`<`MAX_RETRY`): `retry_cnt`+1, go to START.
    - Otherwise: set `ch_fail[cur_ch]`, go to NEXT.
  - **NEXT**: `cur_ch`+1, go to SELECT.
  - **FINISH**: `all_done`=1; `all_ok`=(`ch_ok`==mask)&&(mask≠0); go to IDLE.
- `busy`=1 in every state except IDLE.
- `train_req` while `busy` is ignored.
- `train_abort` in any non-IDLE state:
  - all `cmd_start_training` go to 0 the next cycle;
  - go to IDLE with `all_done`=0;
  - `ch_ok`/`ch_fail` keep their partial values.
- `train_abort` and `train_req` in the same cycle in IDLE: the request is accepted.
- At most one bit of `cmd_start_training` is high at any time.
- Timeout counter: 20 bits minimum (`$clog2(TIMEOUT_CYC+1)`). It saturates and never wraps.

## Timing
- `train_req` at cycle 0 → SELECT at cycle 1. For channel 0 enabled, `cmd_start_training[0]` is high over cycles 3..2+`START_HOLD`.
- Each masked-off channel costs 1 cycle in SELECT.
- From `training_done` rising to `ch_ok`/`ch_fail` set: 2 cycles (WAIT_DONE→EVAL, then register).
- The last channel's EVAL → `all_done` high 3 cycles later.
- No synchronisers on the inputs: the aligners share `clk_rxg`.

## Configuration
- `LVDS_TRAIN_AUTO_RETRY_EN` defined: a failed or timed-out channel is retrained up to `MAX_RETRY` extra times before `ch_fail` is set.
- Undefined: one attempt per channel; `retry_cnt` is tied to 0.

## Structure
- Shared package `lvds_train_pkg`: state enum (IDLE, SELECT, START, WAIT_CLR, WAIT_DONE, EVAL, NEXT, FINISH) and the default `START_HOLD`/`TIMEOUT_CYC` constants.
- Sub-module `train_timeout_cnt`: a clear/enable saturating counter with a terminal flag, reused for the START hold count and the timeout.

## Test plan
- `CH_NUM`=4, mask=4'b1111, each channel model raises done with `loc_ok`=1 after 500 cycles → `ch_ok`=4'hF, `all_ok`=1, `all_done`=1, starts strictly sequential, each start high for 8 cycles.
- mask=4'b0101 → only channels 0 and 2 started; `ch_ok`=4'b0101, `all_ok`=1.
- Channel 1 returns `loc_ok`=0 twice then 1, with the macro defined → three starts on channel 1, `ch_ok[1]`=1. Same case without the macro → one start, `ch_fail[1]`=1, `all_ok`=0.
- Channel 2 never raises done, `TIMEOUT_CYC`=1000 → `timeout_flag`=1, `ch_fail[2]`=1, channel 3 still trained.
- Channel done flag stuck at 1 from a previous pass → held in WAIT_CLR until it drops, no false pass.
- `train_abort` mid-START on channel 1 → start drops next cycle, `busy`=0, `all_done`=0; mask=0 request → `all_done`=1, `all_ok`=0 within 6 cycles.
